// File: rtl/dac_spi_multi.sv
// Multi-channel SPI-style DAC driver: serialises N_CH words MSB first per start
// request and drives CS, SCK, SDI and LDAC, with per-word or simultaneous LDAC.
`timescale 1ns/1ps

module dac_spi_multi #(
    parameter int DATA_W    = 16,
    parameter int N_CH      = 4,
    parameter int CH_W      = 2,
    parameter int SCK_DIV   = 2,
    parameter int T_LS      = 4,
    parameter int T_LD      = 7,
    parameter int LDAC_MODE = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     key_state,
    input  logic                     start,
    input  logic [N_CH*DATA_W-1:0]   data_in,
    output logic                     busy,
    output logic                     done,
    output logic                     cs,
    output logic                     sck,
    output logic                     sdi,
    output logic                     ldac
);

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int DIV_W = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam int T_MAX = (T_LS > T_LD) ? T_LS : T_LD;
    localparam int T_W   = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, CS_HI, LDAC_LO} state_t;

    state_t                   state_q, state_d;
    logic [N_CH*DATA_W-1:0]   shadow_q, shadow_d;
    logic [DATA_W-1:0]        shreg_q, shreg_d;
    logic [CH_W-1:0]          ch_q, ch_d;
    logic [BIT_W-1:0]         bit_q, bit_d;
    logic [DIV_W-1:0]         div_q, div_d;
    logic [T_W-1:0]           tcnt_q, tcnt_d;
    logic                     sck_d, cs_d, sdi_d, ldac_d, busy_d, done_d;

    logic div_tick, fall_tick, word_end, ls_end, ld_end, last_ch, go, next_word;

    assign div_tick  = (div_q == DIV_W'(SCK_DIV - 1));
    assign fall_tick = (state_q == SHIFT) && div_tick && sck;
    assign word_end  = fall_tick && (bit_q == BIT_W'(DATA_W - 1));
    assign ls_end    = (tcnt_q == T_W'(T_LS - 1));
    assign ld_end    = (tcnt_q == T_W'(T_LD - 1));
    assign last_ch   = (ch_q == CH_W'(N_CH - 1));
    assign go        = (state_q == IDLE) && start && key_state;
    // The shadow register shifts down one word per load, so its low word is always the next to send.
    assign next_word = key_state &&
                       (((state_q == CS_HI) && ls_end && (LDAC_MODE != 0) && !last_ch) ||
                        ((state_q == LDAC_LO) && ld_end && !last_ch));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every comb output gets a default first so no latch is inferred on unlisted paths.
    always_comb begin
        state_d = state_q;
        if (!key_state) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start)    state_d = SHIFT;
                SHIFT:   if (word_end) state_d = CS_HI;
                CS_HI:   if (ls_end)   state_d = ((LDAC_MODE == 0) || last_ch) ? LDAC_LO : SHIFT;
                LDAC_LO: if (ld_end)   state_d = last_ch ? IDLE : SHIFT;
                default:               state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        shadow_d = shadow_q;
        shreg_d  = shreg_q;
        ch_d     = ch_q;
        bit_d    = '0;
        div_d    = '0;
        sck_d    = 1'b0;
        tcnt_d   = '0;

        if (go) begin
            shadow_d = data_in;
            shreg_d  = data_in[DATA_W-1:0];
            ch_d     = '0;
        end else if (next_word) begin
            shadow_d = shadow_q >> DATA_W;
            shreg_d  = shadow_d[DATA_W-1:0];
            ch_d     = ch_q + 1'b1;
        end

        // SCK only runs while staying in SHIFT; entry and exit leave it low with counters cleared.
        if ((state_q == SHIFT) && (state_d == SHIFT)) begin
            div_d = div_tick ? '0 : div_q + 1'b1;
            sck_d = div_tick ? ~sck : sck;
            bit_d = bit_q;
            if (fall_tick) begin
                bit_d   = bit_q + 1'b1;
                shreg_d = shreg_q << 1;
            end
        end

        if ((state_d == state_q) && ((state_q == CS_HI) || (state_q == LDAC_LO)))
            tcnt_d = tcnt_q + 1'b1;

        if (state_d == IDLE)
            ch_d = '0;

        cs_d   = (state_d != SHIFT);
        ldac_d = (state_d != LDAC_LO);
        busy_d = (state_d != IDLE);
        sdi_d  = (state_d == SHIFT) && shreg_d[DATA_W-1];
        done_d = key_state && (state_q == LDAC_LO) && ld_end && last_ch;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            ch_q    <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            tcnt_q  <= '0;
            sck     <= 1'b0;
            cs      <= 1'b1;
            sdi     <= 1'b0;
            ldac    <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            ch_q    <= ch_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            tcnt_q  <= tcnt_d;
            sck     <= sck_d;
            cs      <= cs_d;
            sdi     <= sdi_d;
            ldac    <= ldac_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // NOTE: the shadow words are pure data, always loaded before use, so they carry no reset.
    always_ff @(posedge clk) begin
        shadow_q <= shadow_d;
    end

endmodule

// File: tb/tb_dac_spi_multi.sv
// Directed self-checking bench for dac_spi_multi: per-word and simultaneous LDAC,
// fast SCK single channel, restart immunity, key_state abort and async reset.
`timescale 1ns/1ps

module tb_dac_spi_multi;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic key_state = 1'b1;
    logic st0 = 1'b0, st1 = 1'b0, st2 = 1'b0;
    logic [63:0] d0 = '0, d1 = '0;
    logic [15:0] d2 = '0;
    logic busy0, done0, cs0, sck0, sdi0, ldac0;
    logic busy1, done1, cs1, sck1, sdi1, ldac1;
    logic busy2, done2, cs2, sck2, sdi2, ldac2;

    always #5 clk = ~clk;

    dac_spi_multi #(.LDAC_MODE(0)) u_m0 (
        .clk(clk), .rst_n(rst_n), .key_state(key_state), .start(st0), .data_in(d0),
        .busy(busy0), .done(done0), .cs(cs0), .sck(sck0), .sdi(sdi0), .ldac(ldac0));

    dac_spi_multi #(.LDAC_MODE(1)) u_m1 (
        .clk(clk), .rst_n(rst_n), .key_state(key_state), .start(st1), .data_in(d1),
        .busy(busy1), .done(done1), .cs(cs1), .sck(sck1), .sdi(sdi1), .ldac(ldac1));

    dac_spi_multi #(.N_CH(1), .CH_W(1), .SCK_DIV(1)) u_s (
        .clk(clk), .rst_n(rst_n), .key_state(key_state), .start(st2), .data_in(d2),
        .busy(busy2), .done(done2), .cs(cs2), .sck(sck2), .sdi(sdi2), .ldac(ldac2));

    int sel = 0;
    logic m_cs, m_sck, m_sdi, m_ldac, m_busy, m_done;
    assign m_cs   = (sel == 0) ? cs0   : (sel == 1) ? cs1   : cs2;
    assign m_sck  = (sel == 0) ? sck0  : (sel == 1) ? sck1  : sck2;
    assign m_sdi  = (sel == 0) ? sdi0  : (sel == 1) ? sdi1  : sdi2;
    assign m_ldac = (sel == 0) ? ldac0 : (sel == 1) ? ldac1 : ldac2;
    assign m_busy = (sel == 0) ? busy0 : (sel == 1) ? busy1 : busy2;
    assign m_done = (sel == 0) ? done0 : (sel == 1) ? done1 : done2;

    int n_cmp = 0;
    int n_err = 0;

    // Pin monitor: captures words on SCK rises and measures CS/LDAC windows.
    int n_words = 0, n_ldac = 0, done_cnt = 0, done_ok = 0, busy_cyc = 0;
    int ovl_cnt = 0, rise_cnt = 0, sck_hi = 0, sdi_hi = 0;
    int cs_run = 0, ldac_run = 0, gap_run = 0;
    bit gap_act = 1'b0;
    logic [15:0] shift_w = '0;
    logic [15:0] words [64];
    int cs_len [64];
    int ldac_len [64];
    int gap_len [64];
    logic p_cs = 1'b1, p_sck = 1'b0, p_ldac = 1'b1, p_busy = 1'b0;

    always @(negedge clk) begin
        if (!m_cs) cs_run++;
        if (m_sck && !p_sck) begin
            shift_w = {shift_w[14:0], m_sdi};
            rise_cnt++;
        end
        if (m_sck) sck_hi++;
        if (m_sdi) sdi_hi++;
        if (m_busy) busy_cyc++;
        if (m_done) begin
            done_cnt++;
            if (p_busy && !m_busy) done_ok++;
        end
        if (!m_cs && !m_ldac) ovl_cnt++;
        if (!m_cs) gap_act = 1'b0;
        if (m_cs && !p_cs) begin
            words[n_words % 64]  = shift_w;
            cs_len[n_words % 64] = cs_run;
            n_words++;
            cs_run  = 0;
            gap_run = 1;
            gap_act = 1'b1;
        end else if (gap_act && m_ldac) begin
            gap_run++;
        end
        if (!m_ldac) begin
            ldac_run++;
            if (p_ldac) begin
                gap_len[n_ldac % 64] = gap_act ? gap_run : 0;
                gap_act = 1'b0;
            end
        end
        if (m_ldac && !p_ldac) begin
            ldac_len[n_ldac % 64] = ldac_run;
            n_ldac++;
            ldac_run = 0;
        end
        p_cs   = m_cs;
        p_sck  = m_sck;
        p_ldac = m_ldac;
        p_busy = m_busy;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        if (sel == 0) st0 = 1'b1;
        else if (sel == 1) st1 = 1'b1;
        else st2 = 1'b1;
        @(negedge clk);
        st0 = 1'b0;
        st1 = 1'b0;
        st2 = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!m_busy) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, " idle"}, 64'(ok), 64'd1);
        repeat (3) @(negedge clk);
    endtask

    // Full 4-channel sequence on u_m0 / u_m1, optionally with a start retry and new data mid-way.
    task automatic run_seq(input string tag, input logic [63:0] data, input bit restart,
                           input int exp_busy, input int exp_ldacs);
        int w0 = n_words, l0 = n_ldac, dn0 = done_cnt, dk0 = done_ok, b0 = busy_cyc, ov0 = ovl_cnt;
        if (sel == 0) d0 = data; else d1 = data;
        pulse_start();
        if (restart) begin
            repeat (100) @(negedge clk);
            if (sel == 0) d0 = ~data; else d1 = ~data;
            pulse_start();
        end
        wait_idle(tag, 600);
        check({tag, " nwords"}, 64'(n_words - w0), 64'd4);
        for (int k = 0; k < 4; k++) begin
            check({tag, " word"}, 64'(words[(w0 + k) % 64]), 64'(data[16*k +: 16]));
            check({tag, " cs_len"}, 64'(cs_len[(w0 + k) % 64]), 64'd64);
        end
        check({tag, " nldac"}, 64'(n_ldac - l0), 64'(exp_ldacs));
        for (int k = 0; k < exp_ldacs; k++) begin
            check({tag, " ldac_len"}, 64'(ldac_len[(l0 + k) % 64]), 64'd7);
            check({tag, " ls_gap"}, 64'(gap_len[(l0 + k) % 64]), 64'd4);
        end
        check({tag, " busy_cyc"}, 64'(busy_cyc - b0), 64'(exp_busy));
        check({tag, " done_cnt"}, 64'(done_cnt - dn0), 64'd1);
        check({tag, " done_at_end"}, 64'(done_ok - dk0), 64'd1);
        check({tag, " overlap"}, 64'(ovl_cnt - ov0), 64'd0);
    endtask

    task automatic run_single(input string tag, input logic [15:0] data, input int exp_sdi_hi);
        int w0 = n_words, r0 = rise_cnt, h0 = sck_hi, s0 = sdi_hi, b0 = busy_cyc;
        int ov0 = ovl_cnt, l0 = n_ldac, dn0 = done_cnt;
        d2 = data;
        pulse_start();
        wait_idle(tag, 200);
        check({tag, " word"}, 64'(words[w0 % 64]), 64'(data));
        check({tag, " cs_len"}, 64'(cs_len[w0 % 64]), 64'd32);
        check({tag, " rises"}, 64'(rise_cnt - r0), 64'd16);
        check({tag, " sck_hi"}, 64'(sck_hi - h0), 64'd16);
        check({tag, " sdi_hi"}, 64'(sdi_hi - s0), 64'(exp_sdi_hi));
        check({tag, " busy_cyc"}, 64'(busy_cyc - b0), 64'd43);
        check({tag, " nldac"}, 64'(n_ldac - l0), 64'd1);
        check({tag, " done_cnt"}, 64'(done_cnt - dn0), 64'd1);
        check({tag, " overlap"}, 64'(ovl_cnt - ov0), 64'd0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, " cs"}, 64'(cs0), 64'd1);
        check({tag, " sck"}, 64'(sck0), 64'd0);
        check({tag, " sdi"}, 64'(sdi0), 64'd0);
        check({tag, " ldac"}, 64'(ldac0), 64'd1);
        check({tag, " busy"}, 64'(busy0), 64'd0);
        check({tag, " done"}, 64'(done0), 64'd0);
    endtask

    localparam logic [63:0] DATA_A = {16'hF00F, 16'h1234, 16'hA5A5, 16'h8001};
    localparam logic [63:0] DATA_B = {16'h0FF0, 16'h5A5A, 16'hC3C3, 16'h7FFE};

    initial begin
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_idle("post_reset");

        sel = 0;
        run_seq("mode0", DATA_A, 1'b0, 300, 4);

        sel = 1;
        run_seq("mode1", DATA_A, 1'b0, 279, 1);

        sel = 2;
        run_single("fast_ffff", 16'hFFFF, 32);
        run_single("fast_0000", 16'h0000, 0);

        sel = 0;
        run_seq("restart", DATA_B, 1'b1, 300, 4);

        // Abort in bit 7 of channel 2 (third word).
        begin
            int dn0;
            d0 = DATA_A;
            pulse_start();
            repeat (178) @(negedge clk);
            check("abort mid_word cs", 64'(cs0), 64'd0);
            dn0 = done_cnt;
            key_state = 1'b0;
            @(negedge clk);
            check_idle("abort");
            repeat (20) @(negedge clk);
            check("abort no_done", 64'(done_cnt - dn0), 64'd0);
            key_state = 1'b1;
            repeat (2) @(negedge clk);
        end
        run_seq("after_abort", DATA_B, 1'b0, 300, 4);

        // Asynchronous reset while LDAC is low.
        begin
            bit seen = 1'b0;
            int b0, dn0;
            d0 = DATA_A;
            pulse_start();
            for (int i = 0; i < 400; i++) begin
                @(negedge clk);
                if (!ldac0) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("rst ldac_seen", 64'(seen), 64'd1);
            #2 rst_n = 1'b0;
            #1 check_idle("rst_async");
            @(negedge clk);
            rst_n = 1'b1;
            b0  = busy_cyc;
            dn0 = done_cnt;
            repeat (30) @(negedge clk);
            check("rst stays_idle busy", 64'(busy_cyc - b0), 64'd0);
            check("rst stays_idle done", 64'(done_cnt - dn0), 64'd0);
            check_idle("rst_after");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
